// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the serial parity receiver: FSM state encoding and
// bit-counter sizing.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Counter width for a given frame width; never narrower than one bit.
  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  // Default frame width and the matching counter width.
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W      = cnt_w(DATA_W_DEF);

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial receive port bundle: strobe/line in, parallel word and status out.
// Optional: SERIAL_RX_STOP_EN adds the frame_err pulse.
interface serial_parity_rx_if #(
  parameter int DATA_W = 4
);
  logic              bit_en;
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              parity_out;
  logic              valid;
  logic              busy;
`ifdef SERIAL_RX_STOP_EN
  logic              frame_err;
`endif

  // Line driver / consumer side
  modport master (
    output bit_en, rx_in,
    input  data_out, parity_out, valid, busy
`ifdef SERIAL_RX_STOP_EN
    , input frame_err
`endif
  );

  // Receiver side
  modport slave (
    input  bit_en, rx_in,
    output data_out, parity_out, valid, busy
`ifdef SERIAL_RX_STOP_EN
    , output frame_err
`endif
  );
endinterface

// File: rtl/serial_parity_rx.sv
// LSB-first serial deserialiser: start bit, DATA_W data bits, parity bit
// (plus a stop bit when SERIAL_RX_STOP_EN is defined). Emits a one-cycle
// valid strobe when data_out/parity_out are refreshed. Parity is passed
// through unchecked for the downstream checker.
module serial_parity_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_parity_rx_if.slave rx
);

  localparam int                CW   = cnt_w(DATA_W);
  localparam logic [CW-1:0]     LAST = CW'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d, sr_shift;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              valid_q, valid_d;
`ifdef SERIAL_RX_STOP_EN
  logic              par_sh_q, par_sh_d;
  logic              ferr_q, ferr_d;
`endif

  // New bit enters at the MSB so the first bit received ends up in bit 0.
  if (DATA_W == 1) begin : g_sh1
    assign sr_shift = rx.rx_in;
  end else begin : g_shn
    assign sr_shift = {rx.rx_in, sr_q[DATA_W-1:1]};
  end

  // Next-state and datapath updates; everything holds unless bit_en is high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    data_d   = data_q;
    par_d    = par_q;
    valid_d  = 1'b0;
`ifdef SERIAL_RX_STOP_EN
    par_sh_d = par_sh_q;
    ferr_d   = 1'b0;
`endif
    if (rx.bit_en) begin
      case (state_q)
        IDLE: begin
          if (!rx.rx_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          sr_d = sr_shift;
          if (cnt_q == LAST) state_d = PARITY;
          else               cnt_d   = cnt_q + 1'b1;
        end
        PARITY: begin
`ifdef SERIAL_RX_STOP_EN
          // Hold parity aside until the stop bit proves the frame good.
          par_sh_d = rx.rx_in;
          state_d  = STOP;
`else
          data_d  = sr_q;
          par_d   = rx.rx_in;
          valid_d = 1'b1;
          state_d = IDLE;
`endif
        end
        STOP: begin
`ifdef SERIAL_RX_STOP_EN
          if (rx.rx_in) begin
            data_d  = sr_q;
            par_d   = par_sh_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
`endif
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SERIAL_RX_STOP_EN
      par_sh_q <= 1'b0;
      ferr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      data_q   <= data_d;
      par_q    <= par_d;
      valid_q  <= valid_d;
`ifdef SERIAL_RX_STOP_EN
      par_sh_q <= par_sh_d;
      ferr_q   <= ferr_d;
`endif
    end
  end

  assign rx.data_out   = data_q;
  assign rx.parity_out = par_q;
  assign rx.valid      = valid_q;
  assign rx.busy       = (state_q != IDLE);
`ifdef SERIAL_RX_STOP_EN
  assign rx.frame_err  = ferr_q;
`endif

endmodule
